// File: rtl/conv_encoder_punct.sv
// K=7 rate-1/2 convolutional encoder (g0=133o, g1=171o) with 2/3 and 3/4 puncturing.
// Coded bits drain through a small queue, one per clock, with upstream throttled by Ready.
module conv_encoder_punct #(
  parameter int QDEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic [1:0] Rate,
  input  logic       En,
  input  logic       Data,
  output logic       Ready,
  output logic       Out,
  output logic       Out_valid
);

  logic [5:0]        sreg_q, sreg_d;
  logic [1:0]        phase_q, phase_d;
  logic [1:0]        rate_q, rate_d;
  logic [2:0]        count_q, count_d;
  logic [QDEPTH-1:0] queue_q, queue_d;
  logic              valid_q, valid_d;

  logic              accept;
  logic              pop;
  logic              bit_a, bit_b;
  logic [1:0]        phase_last;
  logic [1:0]        push_n;
  logic [1:0]        push_bits;
  logic [QDEPTH-1:0] rem;
  logic [2:0]        rem_cnt;

  // Ready already folds in !Clear, so accept never fires on a Clear edge.
  assign Ready     = (count_q != 3'(QDEPTH)) && !Clear;
  assign accept    = En && Ready;
  assign pop       = (count_q != 3'd0);
  assign bit_a     = Data ^ sreg_q[1] ^ sreg_q[2] ^ sreg_q[4] ^ sreg_q[5];
  assign bit_b     = Data ^ sreg_q[0] ^ sreg_q[1] ^ sreg_q[2] ^ sreg_q[5];
  assign Out       = queue_q[0];
  assign Out_valid = valid_q;

  always_comb begin
    case (rate_q)
      2'b01:   phase_last = 2'd1;
      2'b10:   phase_last = 2'd2;
      default: phase_last = 2'd0;
    endcase
  end

  // push_bits[0] is appended first.
  always_comb begin
    push_n    = 2'd0;
    push_bits = 2'b00;
    if (accept) begin
      case (phase_q)
        2'd0: begin
          push_n    = 2'd2;
          push_bits = {bit_b, bit_a};
        end
        2'd1: begin
          push_n    = 2'd1;
          push_bits = {1'b0, bit_a};
        end
        default: begin
          push_n    = 2'd1;
          push_bits = {1'b0, bit_b};
        end
      endcase
    end
  end

  // Popping shifts zeros in from the top so an empty queue presents Out=0.
  always_comb begin
    rem     = pop ? (queue_q >> 1) : queue_q;
    rem_cnt = count_q - {2'b00, pop};
    queue_d = rem;
    for (int i = 0; i < QDEPTH; i++) begin
      if ((push_n != 2'd0) && (3'(i) == rem_cnt))
        queue_d[i] = push_bits[0];
      if ((push_n == 2'd2) && (3'(i) == rem_cnt + 3'd1))
        queue_d[i] = push_bits[1];
    end
    count_d = rem_cnt + {1'b0, push_n};
    sreg_d  = accept ? {sreg_q[4:0], Data} : sreg_q;
    phase_d = phase_q;
    if (accept)
      phase_d = (phase_q == phase_last) ? 2'd0 : phase_q + 2'd1;
    rate_d = rate_q;
    if (Clear) begin
      queue_d = '0;
      count_d = '0;
      sreg_d  = '0;
      phase_d = '0;
      rate_d  = Rate;
    end
    valid_d = (count_d != 3'd0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sreg_q  <= '0;
      phase_q <= '0;
      rate_q  <= '0;
      count_q <= '0;
      queue_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      count_q <= count_d;
      queue_q <= queue_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: doc/conv_encoder_punct.md
Name: conv_encoder_punct

Overview:
- Rate-1/2, K=7 convolutional encoder (802.11a, g0=133o, g1=171o) with puncturing to 2/3 or 3/4.
- Sits directly downstream of the scrambler: consumes its serial scrambled bit stream.
- Emits a serial coded bit stream, at most one bit per clock, to the interleaver.
- Upstream is throttled by a ready signal so no coded bit is ever dropped.

Parameters:
QDEPTH, 4, output bit-queue depth. Fixed; design is only required for 4.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Clear  input  1  synchronous per-packet init; also latches Rate
Rate  input  2  00=1/2, 01=2/3, 10=3/4, 11=treated as 1/2; sampled only on Clear
En  input  1  Data valid from scrambler
Data  input  1  scrambled data bit
Ready  output  1  block can accept a bit this cycle
Out  output  1  coded bit
Out_valid  output  1  Out holds a valid coded bit this cycle

Behaviour:
- Accept: a rising edge with En=1 and Ready=1 and Clear=0.
- Reset values: shift register s[5:0]=0, puncture phase=0, rate_q=00, queue count=0, queue contents=0, Out=0, Out_valid=0.
- Shift register: s[0]=d(n-1) ... s[5]=d(n-6).
  - A = d^s[1]^s[2]^s[4]^s[5]
  - B = d^s[0]^s[1]^s[2]^s[5]
  - On accept: s <= {s[4:0], d}.
- Puncture phase counter: advances on each accept. Wraps at 1 (rate 1/2), 2 (rate 2/3), 3 (rate 3/4).
- Bits pushed per accept (A before B):
  - 1/2: phase0 -> A,B.
  - 2/3: phase0 -> A,B; phase1 -> A.
  - 3/4: phase0 -> A,B; phase1 -> A; phase2 -> B.
- Queue (3-bit count, 0..4):
  - Out = queue head, Out_valid = (count!=0); both registered state.
  - Every edge with count!=0 pops the head.
  - Push/pop in the same edge are legal: count_next = count - pop + push.
  - Pushed bits append behind the remaining entries, in order.
- Ready = (count!=4) && !Clear. Combinational from registers plus Clear.
  - Guarantees count_next <= 4 in all cases.
- Latency: the first coded bit of an accepted input appears on Out/Out_valid in the cycle after the accept edge.
- Output is gap-free while the queue is non-empty.
- Throughput at rate 1/2 with En held high: Ready settles to alternating 1/0, giving 1 input per 2 clocks.
- Clear=1 at an edge:
  - s=0, phase=0, count=0, Out_valid<=0, rate_q<=Rate.
  - Any En that cycle is ignored.
  - Clear wins over a simultaneous accept or pop.
- Rate changes without Clear have no effect.
- Reset asserted mid-stream: all state returns to reset values immediately, with no clock needed. Queued bits are discarded.
- Tail/zero-termination is upstream's responsibility: it feeds six zeros. The block has no packet-length knowledge.

Test Plan:
1. Reset, Clear with Rate=00, feed 1 then six 0s (En=1 whenever Ready) -> Out_valid bits = 1,1,0,1,1,1,1,1,0,0,1,0,1,1 (14 bits). First bit appears 1 cycle after the first accept.
2. Clear with Rate=10, same 7-bit impulse -> Out = 1,1,0,1,1,1,0,0,1,1 (10 bits). Phase wraps after the 3rd and 6th accepts.
3. Clear with Rate=01, same impulse -> Out = 1,1,0,1,1,1,0,0,1,1,1 (11 bits).
4. Rate=00, En held high for 20 cycles -> Ready pattern settles to 1,0 alternating; Out_valid stays 1 after the first push; count never exceeds 4; 10 inputs yield 20 contiguous coded bits.
5. Mid-stream Clear with Rate=10 while count=3 and En=1 -> that En is not accepted; Out_valid=0 next cycle. The next impulse produces the rate-3/4 sequence of test 2 from phase 0.
6. Reset pulsed (asynchronous, between clock edges) while Out_valid=1 -> Out, Out_valid, and Ready (count=0) change without waiting for a clock edge. After release, rate_q=1/2 and the impulse yields the sequence of test 1 without any Clear.
